// File: rtl/lsu_mem_stage_if.sv
// Memory bus between the LSU memory stage (master) and the data memory (slave).
// Handshake: mem_req and all request fields are held stable by the master until
// the slave answers with a single-cycle mem_ack; mem_rdata is valid only while mem_ack is 1.
interface lsu_mem_stage_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_addr, mem_we, mem_wstrb, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_addr, mem_we, mem_wstrb, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: one outstanding word-aligned bus access per instruction,
// with lane steering for stores, load extraction/extension, fault detection and timeout.
module lsu_mem_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    start,
    input  logic                    memory_en,
    input  logic [1:0]              store_size,
    input  logic [2:0]              funct3,
    input  logic [31:0]             addr,
    input  logic [31:0]             wdata,
    lsu_mem_stage_if.master         bus,
    output logic                    stall,
    output logic                    done,
    output logic [31:0]             load_data,
    output logic                    fault,
    output logic [1:0]              dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t      state, state_d;
    logic [CW-1:0] cnt;
    logic [31:0] addr_q;
    logic        we_q;
    logic [3:0]  wstrb_q;
    logic [31:0] wdata_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic        load_q;
    logic        fault_q;

    logic        accept;
    logic        is_load, is_half, is_word;
    logic        misaligned, illegal, bad;
    logic [3:0]  wstrb_d;
    logic [31:0] wdata_d;
    logic        timeout_hit;
    logic [31:0] rshift;
    logic [15:0] half_sel;
    logic [31:0] ext_data;

    assign accept  = (state == IDLE) && start && memory_en;
    assign is_load = (store_size == 2'b11);
    assign is_half = (store_size == 2'b01) || (is_load && funct3[1:0] == 2'b01);
    assign is_word = (store_size == 2'b10) || (is_load && funct3 == 3'b010);
    assign misaligned = (is_half && addr[0]) || (is_word && addr[1:0] != 2'b00);
    assign illegal = is_load && (funct3 == 3'b011 || funct3[2:1] == 2'b11);
    assign bad     = misaligned || illegal;

    // Narrow stores are replicated across all lanes; the strobe picks the live bytes.
    always_comb begin
        wstrb_d = 4'b0000;
        wdata_d = 32'h0;
        case (store_size)
            2'b00: begin
                wstrb_d = 4'b0001 << addr[1:0];
                wdata_d = {4{wdata[7:0]}};
            end
            2'b01: begin
                wstrb_d = 4'b0011 << addr[1:0];
                wdata_d = {2{wdata[15:0]}};
            end
            2'b10: begin
                wstrb_d = 4'b1111;
                wdata_d = wdata;
            end
            default: begin
                wstrb_d = 4'b0000;
                wdata_d = 32'h0;
            end
        endcase
    end

    assign timeout_hit = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));

    assign rshift   = bus.mem_rdata >> {off_q, 3'b000};
    assign half_sel = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

    always_comb begin
        ext_data = bus.mem_rdata;
        case (f3_q)
            3'b000:  ext_data = {{24{rshift[7]}}, rshift[7:0]};
            3'b001:  ext_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  ext_data = {24'h0, rshift[7:0]};
            3'b101:  ext_data = {16'h0, half_sel};
            default: ext_data = bus.mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (accept) state_d = bad ? DONE : REQ;
            REQ:  if (bus.mem_ack || timeout_hit) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt       <= '0;
            addr_q    <= 32'h0;
            we_q      <= 1'b0;
            wstrb_q   <= 4'b0000;
            wdata_q   <= 32'h0;
            off_q     <= 2'b00;
            f3_q      <= 3'b000;
            load_q    <= 1'b0;
            fault_q   <= 1'b0;
            load_data <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q    <= {addr[31:2], 2'b00};
                        we_q      <= !is_load;
                        wstrb_q   <= wstrb_d;
                        wdata_q   <= wdata_d;
                        off_q     <= addr[1:0];
                        f3_q      <= funct3;
                        load_q    <= is_load;
                        fault_q   <= bad;
                        cnt       <= '0;
                        load_data <= 32'h0;
                    end
                end
                REQ: begin
                    if (bus.mem_ack) begin
                        load_data <= load_q ? ext_data : 32'h0;
                    end else if (timeout_hit) begin
                        fault_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    fault_q   <= 1'b0;
                    load_data <= 32'h0;
                end
                default: begin
                    fault_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req   = (state == REQ);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_wstrb = wstrb_q;
    assign bus.mem_wdata = wdata_q;

    assign stall     = accept || (state == REQ);
    assign done      = (state == DONE);
    assign fault     = (state == DONE) && fault_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: driver tasks issue accesses and answer the bus,
// monitors pop expected responses and bus requests from queues and compare.
module tb_lsu_mem_stage;
    logic        CLK;
    logic        RST_N;
    logic        start;
    logic        memory_en;
    logic [1:0]  store_size;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic [31:0] load_data;
    logic        fault;
    logic [1:0]  dbg_state;

    lsu_mem_stage_if bus ();

    lsu_mem_stage #(.TIMEOUT(4)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .start      (start),
        .memory_en  (memory_en),
        .store_size (store_size),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .bus        (bus.master),
        .stall      (stall),
        .done       (done),
        .load_data  (load_data),
        .fault      (fault),
        .dbg_state  (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    // {has_req, fault, load_data}
    logic [33:0] exp_q[$];
    // {mem_addr, mem_we, mem_wstrb, mem_wdata}
    logic [68:0] bus_q[$];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (RST_N && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1'b1, 1'b0);
            end else begin
                logic [33:0] e;
                e = exp_q.pop_front();
                check("fault", fault, e[32]);
                check("load_data", load_data, e[31:0]);
                if (e[33] && bus_q.size() != 0) void'(bus_q.pop_front());
            end
        end
    end

    always @(negedge CLK) begin
        if (RST_N && bus.mem_req) begin
            if (bus_q.size() == 0) check("unexpected_req", 1'b1, 1'b0);
            else check("bus_req", {bus.mem_addr, bus.mem_we, bus.mem_wstrb, bus.mem_wdata}, bus_q[0]);
        end
    end

    task automatic access(input logic [1:0] sz, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd, input int ack_wait,
                          input int exp_reqs, input int exp_lat,
                          input logic [33:0] exp_resp, input logic [68:0] exp_bus);
        int cyc;
        int reqs;
        int stalls;
        exp_q.push_back(exp_resp);
        if (exp_resp[33]) bus_q.push_back(exp_bus);
        @(negedge CLK);
        start = 1'b1; memory_en = 1'b1; store_size = sz; funct3 = f3; addr = a; wdata = wd;
        #1 check("stall_on_start", stall, 1'b1);
        @(negedge CLK);
        start = 1'b0; memory_en = 1'b0;
        cyc = 1; reqs = 0; stalls = 1;
        while (!done && cyc < 50) begin
            if (bus.mem_req) begin
                reqs++;
                if (reqs - 1 == ack_wait) begin
                    bus.mem_ack = 1'b1;
                    bus.mem_rdata = rd;
                end
            end
            if (stall) stalls++;
            @(negedge CLK);
            bus.mem_ack = 1'b0;
            bus.mem_rdata = 32'hDEADBEEF;
            cyc++;
        end
        check("done_seen", done, 1'b1);
        check("latency", cyc, exp_lat);
        check("req_cycles", reqs, exp_reqs);
        check("stall_cycles", stalls, exp_reqs + 1);
        check("stall_in_done", stall, 1'b0);
        check("req_in_done", bus.mem_req, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N = 1'b0; start = 1'b0; memory_en = 1'b0; store_size = 2'b00; funct3 = 3'b000;
        addr = 32'h0; wdata = 32'h0; bus.mem_ack = 1'b0; bus.mem_rdata = 32'hDEADBEEF;
        repeat (3) @(negedge CLK);
        check("rst_state", dbg_state, 2'd0);
        check("rst_outs", {bus.mem_req, bus.mem_we, stall, done, fault}, 5'b0);
        check("rst_bus", {bus.mem_addr, bus.mem_wstrb, bus.mem_wdata}, 68'h0);
        check("rst_load_data", load_data, 32'h0);
        RST_N = 1'b1;

        // SB at 0x1002, ack in first REQ cycle
        access(2'b00, 3'b000, 32'h1002, 32'hAABBCCDD, 32'h0, 0, 1, 2,
               {1'b1, 1'b0, 32'h0}, {32'h1000, 1'b1, 4'b0100, 32'hDDDDDDDD});
        // LH / LHU at 0x2002, ack on third REQ cycle
        access(2'b11, 3'b001, 32'h2002, 32'h0, 32'h80011234, 2, 3, 4,
               {1'b1, 1'b0, 32'hFFFF8001}, {32'h2000, 1'b0, 4'b0000, 32'h0});
        access(2'b11, 3'b101, 32'h2002, 32'h0, 32'h80011234, 2, 3, 4,
               {1'b1, 1'b0, 32'h00008001}, {32'h2000, 1'b0, 4'b0000, 32'h0});
        // LB offset 3, LW aligned
        access(2'b11, 3'b000, 32'h1003, 32'h0, 32'h7F000000, 1, 2, 3,
               {1'b1, 1'b0, 32'h0000007F}, {32'h1000, 1'b0, 4'b0000, 32'h0});
        access(2'b11, 3'b010, 32'h4000, 32'h0, 32'h12345678, 0, 1, 2,
               {1'b1, 1'b0, 32'h12345678}, {32'h4000, 1'b0, 4'b0000, 32'h0});
        // LB / LBU offset 1
        access(2'b11, 3'b000, 32'h0101, 32'h0, 32'h0000F100, 0, 1, 2,
               {1'b1, 1'b0, 32'hFFFFFFF1}, {32'h0100, 1'b0, 4'b0000, 32'h0});
        access(2'b11, 3'b100, 32'h0101, 32'h0, 32'h0000F100, 0, 1, 2,
               {1'b1, 1'b0, 32'h000000F1}, {32'h0100, 1'b0, 4'b0000, 32'h0});
        // SW and SH upper half
        access(2'b10, 3'b000, 32'h0010, 32'hCAFEF00D, 32'h0, 0, 1, 2,
               {1'b1, 1'b0, 32'h0}, {32'h0010, 1'b1, 4'b1111, 32'hCAFEF00D});
        access(2'b01, 3'b000, 32'h0022, 32'h1234BEEF, 32'h0, 1, 2, 3,
               {1'b1, 1'b0, 32'h0}, {32'h0020, 1'b1, 4'b1100, 32'hBEEFBEEF});
        // Faults without a bus request
        access(2'b11, 3'b010, 32'h3001, 32'h0, 32'h0, 0, 0, 1, {1'b0, 1'b1, 32'h0}, 69'h0);
        access(2'b01, 3'b000, 32'h3003, 32'h5555, 32'h0, 0, 0, 1, {1'b0, 1'b1, 32'h0}, 69'h0);
        access(2'b11, 3'b011, 32'h3000, 32'h0, 32'h0, 0, 0, 1, {1'b0, 1'b1, 32'h0}, 69'h0);
        access(2'b11, 3'b110, 32'h3000, 32'h0, 32'h0, 0, 0, 1, {1'b0, 1'b1, 32'h0}, 69'h0);
        // Timeout with TIMEOUT=4, then a normal access
        access(2'b11, 3'b010, 32'h5000, 32'h0, 32'h0, -1, 4, 5,
               {1'b1, 1'b1, 32'h0}, {32'h5000, 1'b0, 4'b0000, 32'h0});
        access(2'b00, 3'b000, 32'h5001, 32'h000000A5, 32'h0, 0, 1, 2,
               {1'b1, 1'b0, 32'h0}, {32'h5000, 1'b1, 4'b0010, 32'hA5A5A5A5});

        // start without memory_en
        @(negedge CLK);
        start = 1'b1; memory_en = 1'b0; store_size = 2'b10; addr = 32'h40;
        #1 check("no_mem_stall", stall, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            start = 1'b0;
            check("no_mem_req", bus.mem_req, 1'b0);
            check("no_mem_state", dbg_state, 2'd0);
        end

        // Reset in the middle of REQ
        bus_q.push_back({32'h6000, 1'b0, 4'b0000, 32'h0});
        @(negedge CLK);
        start = 1'b1; memory_en = 1'b1; store_size = 2'b11; funct3 = 3'b010; addr = 32'h6000;
        @(negedge CLK);
        start = 1'b0; memory_en = 1'b0;
        check("mid_req_up", bus.mem_req, 1'b1);
        @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check("rst_req_drop", bus.mem_req, 1'b0);
        check("rst_stall_drop", stall, 1'b0);
        check("rst_done_low", {done, fault}, 2'b00);
        check("rst_state_idle", dbg_state, 2'd0);
        bus_q.delete();
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);
        access(2'b11, 3'b001, 32'h6002, 32'h0, 32'h7ABC0000, 0, 1, 2,
               {1'b1, 1'b0, 32'h00007ABC}, {32'h6000, 1'b0, 4'b0000, 32'h0});

        repeat (3) @(negedge CLK);
        check("exp_q_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Memory-access stage sitting directly downstream of the instruction controller. It turns the controller's `memory_en` and `store_size` decode, plus the ALU-computed address and rs2 data, into a single-outstanding word-aligned bus transaction. It returns sign- or zero-extended load data for the `wdSelect = 01` writeback path and stalls the pipeline until the access completes.

## Interface
- `TIMEOUT`, 255: maximum REQ cycles without `mem_ack` before the access is abandoned with a fault; 0 disables the timeout.
- `CLK`  in  1  single clock, rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `start`  in  1  upstream instruction valid this cycle.
- `memory_en`  in  1  from controller; instruction accesses memory.
- `store_size`  in  2  from controller: 00 byte store, 01 half store, 10 word store, 11 load.
- `funct3`  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- `addr`  in  32  effective byte address from the ALU.
- `wdata`  in  32  rs2 store data.
- `mem_req`  out  1  bus request, held until ack or timeout.
- `mem_addr`  out  32  `{addr[31:2], 2'b00}`.
- `mem_we`  out  1  1 for a store.
- `mem_wstrb`  out  4  byte enables; 0000 for a load.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_ack`  in  1  bus completion; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  32  read data.
- `stall`  out  1  hold the pipeline.
- `done`  out  1  one-cycle completion pulse.
- `load_data`  out  32  extended load result, valid while `done` is 1.
- `fault`  out  1  qualifies `done`: misaligned access, illegal load `funct3`, or timeout.

## Operation
- **FSM states:** IDLE, REQ, DONE.
- **IDLE:**
  - If `start && memory_en`: register `addr`, `wdata`, `store_size`, `funct3`.
  - Go to DONE with fault pending if the access is misaligned or the load `funct3` is illegal; otherwise go to REQ.
  - Otherwise stay in IDLE.
- **Misaligned:** a half access with `addr[0]=1`, or a word access (store_size 10, or load `funct3` 010) with `addr[1:0]≠00`.
- **Illegal load funct3:** 011, 110 or 111, when store_size is 11.
- **REQ:**
  - `mem_req=1`; `mem_addr`, `mem_we`, `mem_wstrb` and `mem_wdata` are driven from the registered values.
  - On `mem_ack`: capture `mem_rdata` and go to DONE.
  - Else increment the timeout counter; when it equals `TIMEOUT` (and `TIMEOUT≠0`), drop the request and go to DONE with fault.
- **DONE:** `done=1` for exactly one cycle, then unconditionally back to IDLE. `start` is not sampled in DONE; upstream advances during this cycle.
- **Store lanes** (`o = addr[1:0]`):
  - Byte: `wstrb = 0001<<o`, `wdata = {4{wdata[7:0]}}`.
  - Half: `wstrb = 0011<<o`, `wdata = {2{wdata[15:0]}}`.
  - Word: `wstrb = 1111`.
- **Load extract:**
  - Select the byte at `rdata[8o+7:8o]`, or the half at `rdata[16·o[1]+15:16·o[1]]`.
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
  - For a store or a fault, `load_data = 0`.
- `start` with `memory_en=0`: no effect, no stall.

## Timing
- **Reset values:** state IDLE; `mem_req`, `mem_we`, `stall`, `done`, `fault` = 0; `mem_addr`, `mem_wstrb`, `mem_wdata`, `load_data`, timeout counter = 0.
- `stall = (IDLE && start && memory_en) || REQ`. `stall` is combinational and drops in the DONE cycle.
- **Minimum latency:** `start` at cycle 0, `mem_req` at cycle 1, `mem_ack` at cycle 1, `done` at cycle 2.
- **Fault with no bus request** (misaligned or illegal): `done` and `fault` at cycle 1; `mem_req` is never asserted.
- **Timeout:** `mem_req` is high for exactly `TIMEOUT` cycles, then `done` and `fault` in the next cycle.
- `mem_ack` while not in REQ is ignored.
- The request registers are stable for the whole of REQ.
- **Reset mid-operation:** `RST_N` low forces IDLE and all outputs low immediately (asynchronously, not waiting for a clock edge), including `mem_req`. No `done` is produced for the aborted access.

## Test plan
- SB: `addr` 0x1002, `wdata` 0xAABBCCDD, `store_size` 00 -> `mem_addr` 0x1000, `wstrb` 0100, `mem_wdata` 0xDDDDDDDD, `mem_we` 1. With ack in the first REQ cycle: `done` at cycle 2, `fault` 0.
- LH then LHU: `addr` 0x2002, `rdata` 0x80011234, ack delayed 3 cycles -> `stall` held 4 cycles; `load_data` 0xFFFF8001, then 0x00008001.
- LB at offset 3 with `rdata` 0x7F000000 -> 0x0000007F. LW at 0x4000 -> `load_data` equals `rdata`.
- LW at 0x3001, SH at 0x3003, and load with `funct3` 011 -> no `mem_req`; `done` and `fault` at cycle 1; `load_data` 0.
- `TIMEOUT`=4, no ack -> `mem_req` high 4 cycles, then `done` and `fault`; the next `start` is accepted normally.
- `RST_N` pulsed low in the middle of REQ -> `mem_req` and `stall` fall without a clock edge, no `done`; the next access works.
